// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: one registered cycle from FSM/display state to pins, no backpressure.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading-zero digits above digit 0.
module seven_seg_scanner #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_DV,
  output logic [6:0]                    o_Segments,
  output logic [DECIMAL_DIGITS-1:0]     o_Anodes,
  output logic [2:0]                    o_Digit_Index
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(DECIMAL_DIGITS - 1);

  typedef enum logic {S_SHOW, S_BLANK} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [2:0]                    idx;
  logic [DECIMAL_DIGITS*4-1:0]   disp;
  logic [3:0]                    digit;
  logic                          hide;
  logic [6:0]                    seg_next;
  logic [DECIMAL_DIGITS-1:0]     an_next;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg7_decode = 7'h40;
      4'd1:    seg7_decode = 7'h79;
      4'd2:    seg7_decode = 7'h24;
      4'd3:    seg7_decode = 7'h30;
      4'd4:    seg7_decode = 7'h19;
      4'd5:    seg7_decode = 7'h12;
      4'd6:    seg7_decode = 7'h02;
      4'd7:    seg7_decode = 7'h78;
      4'd8:    seg7_decode = 7'h00;
      4'd9:    seg7_decode = 7'h10;
      default: seg7_decode = 7'h3F;
    endcase
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // upper_zero[i] is set when digit i and every digit above it are zero
  logic [DECIMAL_DIGITS-1:0] upper_zero;
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = DECIMAL_DIGITS - 1; i >= 0; i--) begin
      run           = run && (disp[i*4 +: 4] == 4'd0);
      upper_zero[i] = run;
    end
  end
`endif

  always_comb begin
    digit    = 4'd0;
    hide     = 1'b0;
    seg_next = 7'h7F;
    an_next  = '1;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (idx == i[2:0]) begin
        digit = disp[i*4 +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        hide  = (i != 0) && upper_zero[i];
`endif
      end
    end
    if (state == S_SHOW && !hide) begin
      seg_next = seg7_decode(digit);
      for (int i = 0; i < DECIMAL_DIGITS; i++)
        an_next[i] = (idx != i[2:0]);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= S_SHOW;
      cnt           <= '0;
      idx           <= '0;
      disp          <= '0;
      o_Segments    <= 7'h7F;
      o_Anodes      <= '1;
      o_Digit_Index <= '0;
    end else begin
      if (i_DV)
        disp <= i_BCD;
      o_Segments    <= seg_next;
      o_Anodes      <= an_next;
      o_Digit_Index <= idx;
      case (state)
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= S_BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= S_SHOW;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_SHOW;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with 2 digits, 4-cycle slots and a 1-cycle blank gap.
module tb_seven_seg_scanner;
  localparam int DD = 2;
  localparam int RD = 4;
  localparam int BC = 1;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] bcd = 8'h00;
  logic [6:0] seg;
  logic [1:0] an;
  logic [2:0] idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [1:0] an1;
    logic       chk1;
  } vec_t;

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       chk_seg;
    logic [2:0] idx;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  seven_seg_scanner #(
    .DECIMAL_DIGITS(DD),
    .REFRESH_DIV(RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_BCD(bcd),
    .i_DV(dv),
    .o_Segments(seg),
    .o_Anodes(an),
    .o_Digit_Index(idx)
  );

  initial forever #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] b, input logic [6:0] s0,
                         input logic [6:0] s1, input bit upper_blank);
    vecs[i].bcd  = b;
    vecs[i].seg0 = s0;
    vecs[i].seg1 = s1;
    vecs[i].an1  = (upper_blank && LZB) ? 2'b11 : 2'b01;
    vecs[i].chk1 = !(upper_blank && LZB);
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [6:0] s, input logic c, input logic [2:0] x);
    exp_t e;
    e.an = a; e.seg = s; e.chk_seg = c; e.idx = x;
    sb.push_back(e);
  endtask

  // advance one clock and compare the outputs against the oldest queued expectation
  task automatic step_pop(input string name);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      cmp({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp({name, "_an"}, an, e.an);
      cmp({name, "_idx"}, idx, e.idx);
      if (e.chk_seg) cmp({name, "_seg"}, seg, e.seg);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dv  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [1:0] prev_an;
    int         last_start;

    set_vec(0, 8'h42, 7'h24, 7'h19, 1'b0);
    set_vec(1, 8'h07, 7'h78, 7'h40, 1'b1);
    set_vec(2, 8'hA5, 7'h12, 7'h3F, 1'b0);
    set_vec(3, 8'h90, 7'h40, 7'h10, 1'b0);
    set_vec(4, 8'h00, 7'h40, 7'h40, 1'b1);
    set_vec(5, 8'h3B, 7'h3F, 7'h30, 1'b0);
    set_vec(6, 8'h86, 7'h02, 7'h00, 1'b0);
    set_vec(7, 8'h1F, 7'h3F, 7'h79, 1'b0);

    // reset state, then digit 0 showing zero after release
    repeat (2) @(negedge clk);
    cmp("rst_an", an, 2'b11);
    cmp("rst_seg", seg, 7'h7F);
    cmp("rst_idx", idx, 3'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rel_an", an, 2'b10);
    cmp("rel_seg", seg, 7'h40);
    cmp("rel_idx", idx, 3'd0);

    // one full steady-state scan period per vector (cycles 11..20 after load)
    foreach (vecs[v]) begin
      do_reset();
      bcd = vecs[v].bcd;
      dv  = 1'b1;
      @(negedge clk);
      dv = 1'b0;
      repeat (9) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        if (k < 4)       push_exp(2'b10, vecs[v].seg0, 1'b1, 3'd0);
        else if (k == 4) push_exp(2'b11, 7'h7F, 1'b1, 3'd0);
        else if (k < 9)  push_exp(vecs[v].an1, vecs[v].seg1, vecs[v].chk1, 3'd1);
        else             push_exp(2'b11, 7'h7F, 1'b1, 3'd1);
      end
      for (int k = 0; k < 10; k++)
        step_pop($sformatf("vec%0d_k%0d", v, k));
    end

    // input change without strobe is ignored; mid-slot strobe lands one cycle later
    do_reset();
    bcd = 8'h11;
    dv  = 1'b1;
    @(negedge clk);
    dv  = 1'b0;
    bcd = 8'h99;
    repeat (6) @(negedge clk);
    cmp("nodv_slot1_an", an, 2'b01);
    cmp("nodv_slot1_seg", seg, 7'h79);
    repeat (5) @(negedge clk);
    cmp("nodv_slot0_an", an, 2'b10);
    cmp("nodv_slot0_seg", seg, 7'h79);
    dv = 1'b1;
    push_exp(2'b10, 7'h79, 1'b1, 3'd0);
    push_exp(2'b10, 7'h10, 1'b1, 3'd0);
    push_exp(2'b11, 7'h7F, 1'b1, 3'd0);
    for (int k = 0; k < 4; k++) push_exp(2'b01, 7'h10, 1'b1, 3'd1);
    push_exp(2'b11, 7'h7F, 1'b1, 3'd1);
    push_exp(2'b10, 7'h10, 1'b1, 3'd0);
    step_pop("middv_c0");
    dv = 1'b0;
    for (int k = 1; k < 9; k++) step_pop($sformatf("middv_c%0d", k));

    // asynchronous reset in the middle of slot 1, with a strobe that must be dropped
    do_reset();
    bcd = 8'h42;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (16) @(negedge clk);
    cmp("midrst_pre_an", an, 2'b01);
    #2 rst = 1'b1;
    #1;
    cmp("midrst_an", an, 2'b11);
    cmp("midrst_seg", seg, 7'h7F);
    cmp("midrst_idx", idx, 3'd0);
    bcd = 8'h77;
    dv  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;
    repeat (2) @(negedge clk);
    cmp("postrst_an", an, 2'b10);
    cmp("postrst_seg", seg, 7'h40);
    cmp("postrst_idx", idx, 3'd0);
    repeat (4) @(negedge clk);
    cmp("postrst_s1_an", an, LZB ? 2'b11 : 2'b01);
    cmp("postrst_s1_idx", idx, 3'd1);
    if (!LZB) cmp("postrst_s1_seg", seg, 7'h40);

    // long random run: single active anode, blank gap between slots, fixed period
    do_reset();
    prev_an    = 2'b11;
    last_start = -1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      cmp("onehot", ($countones(~an) > 1), 1'b0);
      cmp("gap", (an != 2'b11 && prev_an != 2'b11 && an != prev_an), 1'b0);
      if (an == 2'b10 && prev_an != 2'b10) begin
        if (last_start >= 0) cmp("period", cyc - last_start, 10);
        last_start = cyc;
      end
      prev_an = an;
      dv  = ($urandom_range(0, 15) == 0);
      bcd = 8'($urandom);
    end
    dv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter DECIMAL_DIGITS, default 2: number of BCD digits accepted and displayed (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is driven per scan slot (>=2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: anti-ghosting gap in cycles between digit slots (>=1).
REQ-004 SHALL have port i_Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_BCD  input  DECIMAL_DIGITS*4  packed BCD value; digit 0 in bits [3:0].
REQ-007 SHALL have port i_DV  input  1  one-cycle strobe qualifying i_BCD.
REQ-008 SHALL have port o_Segments  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port o_Anodes  output  DECIMAL_DIGITS  digit enables, active-low, at most one low at a time.
REQ-010 SHALL have port o_Digit_Index  output  3  index of the digit slot currently scanned.

Function
REQ-011 SHALL capture i_BCD into an internal display register on every rising edge where i_DV=1; i_BCD is ignored when i_DV=0.
REQ-012 SHALL implement a two-state FSM: S_SHOW (selected anode low, segments driven) and S_BLANK (all anodes high, segments 7'h7F).
REQ-013 SHALL stay in S_SHOW for exactly REFRESH_DIV cycles, counted 0..REFRESH_DIV-1, then enter S_BLANK with the counter cleared.
REQ-014 SHALL stay in S_BLANK for exactly BLANK_CYCLES cycles, then increment the digit index and enter S_SHOW.
REQ-015 SHALL wrap the digit index from DECIMAL_DIGITS-1 to 0; one full scan = DECIMAL_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-016 SHALL register o_Segments, o_Anodes, o_Digit_Index; each reflects FSM state, index and display register one cycle after they change.
REQ-017 SHALL decode digit values 0-9 to standard active-low patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
REQ-018 SHALL display a dash (7'h3F) for any digit value 10-15.
REQ-019 SHALL let a capture on the same edge as a digit change take effect in that new slot; a capture mid-slot updates the segments of the current slot one cycle later without restarting the counters.
REQ-020 SHALL not alter scan timing on i_DV; i_DV only writes the display register.

Reset
REQ-021 SHALL on i_Reset=1, regardless of clock, force: FSM=S_SHOW, counter=0, index=0, display register=0, o_Anodes=all 1, o_Segments=7'h7F, o_Digit_Index=0.
REQ-022 SHALL after reset release drive digit 0 (o_Anodes[0]=0, o_Segments=7'h40) from the second rising edge onward.
REQ-023 SHALL on reset asserted mid-scan abandon the slot and restart per REQ-021; a pending i_DV on that edge is discarded.

Configuration
REQ-024 SHALL, with macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, keep the anode high during S_SHOW for any digit index >0 whose value and all higher digits are 0 (digit 0 always shown).
REQ-025 SHALL, without SEVEN_SEG_LEADING_ZERO_BLANK_EN, drive every digit in its slot including leading zeros.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, DECIMAL_DIGITS=2)
REQ-026 SHALL cover: reset then i_BCD=8'h42,i_DV pulse -> slot 0 anodes 2'b10 seg 7'h24 for 4 cycles, 1 cycle 2'b11/7'h7F, slot 1 anodes 2'b01 seg 7'h19; period 10 cycles.
REQ-027 SHALL cover: i_BCD=8'h07 with macro defined -> slot 1 anodes 2'b11 throughout; without macro -> slot 1 anodes 2'b01 seg 7'h40.
REQ-028 SHALL cover: i_BCD=8'hA5 -> slot 0 seg 7'h12, slot 1 seg 7'h3F.
REQ-029 SHALL cover: i_BCD changes 8'h11->8'h99 with i_DV=0 -> display unchanged (7'h79); then i_DV pulse -> 7'h10 one cycle later, slot timing unchanged.
REQ-030 SHALL cover: i_Reset asserted asynchronously mid slot 1 -> anodes 2'b11, seg 7'h7F immediately, index 0, display 0 after release.
REQ-031 SHALL cover: continuous check across 1000 cycles that o_Anodes never has more than one bit low and every slot change includes an all-high cycle.
